// File: rtl/writeback_buffer.sv
// Writeback buffer between a 2-way cache and main memory: a small circular FIFO of
// evicted lines, drained one write at a time, with an associative snoop port for refills.
module writeback_buffer #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wb_valid,
    input  logic [2:0] wb_tag,
    input  logic [1:0] wb_index,
    input  logic [2:0] wb_data,
    output logic       mem_req,
    output logic [4:0] mem_addr,
    output logic [2:0] mem_data,
    input  logic       mem_ack,
    input  logic [2:0] snoop_tag,
    input  logic [1:0] snoop_index,
    output logic       snoop_hit,
    output logic [2:0] snoop_data,
    output logic       full,
    output logic       empty,
    output logic [3:0] count,
    output logic       overflow
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, REQ} state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [PTR_W-1:0]   snoop_pos;
    logic [7:0]         entry_q [DEPTH];
    logic               push, pop;

    assign full  = (count == 4'(DEPTH));
    assign empty = (count == 4'd0);
    // A pop in the same cycle never frees room for a push that arrives while full.
    assign push  = wb_valid && !full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            head_q   <= '0;
            tail_q   <= '0;
            count    <= 4'd0;
            overflow <= 1'b0;
        end else begin
            state_q <= state_d;
            if (push) tail_q <= tail_q + PTR_W'(1);
            if (pop)  head_q <= head_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + 4'd1;
                2'b01:   count <= count - 4'd1;
                default: count <= count;
            endcase
            if (wb_valid && full) overflow <= 1'b1;
        end
    end

    // Entry storage carries no reset; only pointers and count define what is pending.
    always_ff @(posedge clk) begin
        if (push) entry_q[tail_q] <= {wb_tag, wb_index, wb_data};
    end

    always_comb begin
        state_d  = state_q;
        mem_req  = 1'b0;
        mem_addr = 5'd0;
        mem_data = 3'd0;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty) state_d = REQ;
            end
            REQ: begin
                mem_req  = 1'b1;
                mem_addr = entry_q[head_q][7:3];
                mem_data = entry_q[head_q][2:0];
                if (mem_ack) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Walk pending entries oldest to newest so the last match is the newest one.
    always_comb begin
        snoop_hit  = 1'b0;
        snoop_data = 3'd0;
        snoop_pos  = head_q;
        for (int k = 0; k < DEPTH; k++) begin
            snoop_pos = head_q + PTR_W'(k);
            if ((4'(k) < count) && (entry_q[snoop_pos][7:3] == {snoop_tag, snoop_index})) begin
                snoop_hit  = 1'b1;
                snoop_data = entry_q[snoop_pos][2:0];
            end
        end
    end

endmodule

// File: tb/tb_writeback_buffer.sv
// Directed bench for writeback_buffer: per-cycle vector table plus hand-written
// sequences for pointer wrap under simultaneous push/pop and reset during a request.
module tb_writeback_buffer;

    logic       clk, rst_n;
    logic       wb_valid, mem_ack;
    logic [2:0] wb_tag, wb_data, snoop_tag;
    logic [1:0] wb_index, snoop_index;
    logic       mem_req, snoop_hit, full, empty, overflow;
    logic [4:0] mem_addr;
    logic [2:0] mem_data, snoop_data;
    logic [3:0] count;

    int checks = 0;
    int failures = 0;

    writeback_buffer #(.DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_index(wb_index), .wb_data(wb_data),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_data(mem_data), .mem_ack(mem_ack),
        .snoop_tag(snoop_tag), .snoop_index(snoop_index),
        .snoop_hit(snoop_hit), .snoop_data(snoop_data),
        .full(full), .empty(empty), .count(count), .overflow(overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic       wv;
        logic [2:0] wt;
        logic [1:0] wi;
        logic [2:0] wd;
        logic       ack;
        logic [2:0] st;
        logic [1:0] si;
        logic       req;
        logic [4:0] addr;
        logic [2:0] md;
        logic       hit;
        logic [2:0] sd;
        logic [3:0] cnt;
        logic       fl;
        logic       em;
        logic       ov;
    } vec_t;

    vec_t tbl[$];
    logic [7:0] exp_q[$];

    function automatic vec_t v(input logic wv, input logic [2:0] wt, input logic [1:0] wi,
                               input logic [2:0] wd, input logic ack, input logic [2:0] st,
                               input logic [1:0] si, input logic req, input logic [4:0] addr,
                               input logic [2:0] md, input logic hit, input logic [2:0] sd,
                               input logic [3:0] cnt, input logic fl, input logic em,
                               input logic ov);
        return '{wv, wt, wi, wd, ack, st, si, req, addr, md, hit, sd, cnt, fl, em, ov};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_tag = 3'd0; wb_index = 2'd0; wb_data = 3'd0; mem_ack = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_entry(input logic [7:0] e);
        wb_valid = 1'b1; wb_tag = e[7:5]; wb_index = e[4:3]; wb_data = e[2:0];
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();
        snoop_tag = 3'd0; snoop_index = 2'd0;
        #2;
        chk("rst mem_req", mem_req, 0);
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst overflow", overflow, 0);
        chk("rst mem_addr", mem_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();

        // single eviction, spurious ack
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b101,2'b10, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,0));
        tbl.push_back(v(1,3'b101,2'b10,3'b011,0, 3'b101,2'b10, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b101,2'b10, 0,5'b00000,3'b000, 1,3'b011, 1,0,0,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b101,2'b10, 1,5'b10110,3'b011, 1,3'b011, 1,0,0,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b101,2'b10, 1,5'b10110,3'b011, 1,3'b011, 1,0,0,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,1, 3'b101,2'b10, 1,5'b10110,3'b011, 1,3'b011, 1,0,0,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b101,2'b10, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,1, 3'b101,2'b10, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b101,2'b10, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,0));
        // fill, overflow, drain order
        tbl.push_back(v(1,3'b001,2'b00,3'b001,0, 3'b000,2'b00, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,0));
        tbl.push_back(v(1,3'b010,2'b01,3'b010,0, 3'b000,2'b00, 0,5'b00000,3'b000, 0,3'b000, 1,0,0,0));
        tbl.push_back(v(1,3'b011,2'b10,3'b011,0, 3'b000,2'b00, 1,5'b00100,3'b001, 0,3'b000, 2,0,0,0));
        tbl.push_back(v(1,3'b100,2'b11,3'b100,0, 3'b000,2'b00, 1,5'b00100,3'b001, 0,3'b000, 3,0,0,0));
        tbl.push_back(v(1,3'b111,2'b11,3'b111,0, 3'b000,2'b00, 1,5'b00100,3'b001, 0,3'b000, 4,1,0,0));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b111,2'b11, 1,5'b00100,3'b001, 0,3'b000, 4,1,0,1));
        tbl.push_back(v(1,3'b111,2'b11,3'b111,1, 3'b000,2'b00, 1,5'b00100,3'b001, 0,3'b000, 4,1,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b011,2'b10, 0,5'b00000,3'b000, 1,3'b011, 3,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,1, 3'b000,2'b00, 1,5'b01001,3'b010, 0,3'b000, 3,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b000,2'b00, 0,5'b00000,3'b000, 0,3'b000, 2,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,1, 3'b000,2'b00, 1,5'b01110,3'b011, 0,3'b000, 2,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b000,2'b00, 0,5'b00000,3'b000, 0,3'b000, 1,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,1, 3'b000,2'b00, 1,5'b10011,3'b100, 0,3'b000, 1,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b000,2'b00, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,1));
        // snoop: newest match wins, popped entry visible until its edge, free slots ignored
        tbl.push_back(v(1,3'b001,2'b00,3'b100,0, 3'b001,2'b00, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,1));
        tbl.push_back(v(1,3'b001,2'b00,3'b110,0, 3'b001,2'b00, 0,5'b00000,3'b000, 1,3'b100, 1,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b001,2'b00, 1,5'b00100,3'b100, 1,3'b110, 2,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b010,2'b00, 1,5'b00100,3'b100, 0,3'b000, 2,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,1, 3'b001,2'b00, 1,5'b00100,3'b100, 1,3'b110, 2,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b001,2'b00, 0,5'b00000,3'b000, 1,3'b110, 1,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,1, 3'b001,2'b00, 1,5'b00100,3'b110, 1,3'b110, 1,0,0,1));
        tbl.push_back(v(0,3'b000,2'b00,3'b000,0, 3'b001,2'b00, 0,5'b00000,3'b000, 0,3'b000, 0,0,1,1));

        foreach (tbl[i]) begin
            wb_valid = tbl[i].wv; wb_tag = tbl[i].wt; wb_index = tbl[i].wi; wb_data = tbl[i].wd;
            mem_ack = tbl[i].ack; snoop_tag = tbl[i].st; snoop_index = tbl[i].si;
            @(negedge clk);
            chk($sformatf("row%0d mem_req", i), mem_req, tbl[i].req);
            chk($sformatf("row%0d mem_addr", i), mem_addr, tbl[i].addr);
            chk($sformatf("row%0d mem_data", i), mem_data, tbl[i].md);
            chk($sformatf("row%0d snoop_hit", i), snoop_hit, tbl[i].hit);
            chk($sformatf("row%0d snoop_data", i), snoop_data, tbl[i].sd);
            chk($sformatf("row%0d count", i), count, tbl[i].cnt);
            chk($sformatf("row%0d full", i), full, tbl[i].fl);
            chk($sformatf("row%0d empty", i), empty, tbl[i].em);
            chk($sformatf("row%0d overflow", i), overflow, tbl[i].ov);
            step();
        end
        idle_inputs();
        snoop_tag = 3'd0; snoop_index = 2'd0;

        // simultaneous push/pop at count=2, pointers wrap several times
        for (int n = 0; n < 2; n++) begin
            exp_q.push_back({3'(n), 2'(n + 1), ~3'(n)});
            push_entry(exp_q[$]);
            step();
        end
        idle_inputs();
        for (int n = 2; n < 12; n++) begin
            logic [7:0] e;
            e = {3'(n), 2'(n + 1), ~3'(n)};
            push_entry(e);
            mem_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("wrap%0d mem_req", n), mem_req, 1);
            chk($sformatf("wrap%0d mem_addr", n), mem_addr, exp_q[0][7:3]);
            chk($sformatf("wrap%0d mem_data", n), mem_data, exp_q[0][2:0]);
            step();
            void'(exp_q.pop_front());
            exp_q.push_back(e);
            idle_inputs();
            @(negedge clk);
            chk($sformatf("wrap%0d count", n), count, 2);
            chk($sformatf("wrap%0d idle gap", n), mem_req, 0);
            step();
        end
        for (int j = 0; j < 2; j++) begin
            mem_ack = 1'b1;
            @(negedge clk);
            chk($sformatf("wrapdrain%0d mem_addr", j), mem_addr, exp_q[0][7:3]);
            chk($sformatf("wrapdrain%0d mem_data", j), mem_data, exp_q[0][2:0]);
            step();
            void'(exp_q.pop_front());
            mem_ack = 1'b0;
            step();
        end
        @(negedge clk);
        chk("wrap final count", count, 0);
        step();

        // reset in the middle of a request with three entries pending
        for (int n = 0; n < 3; n++) begin
            push_entry({3'(n + 4), 2'(n), 3'(n)});
            step();
        end
        idle_inputs();
        chk("pre-reset mem_req", mem_req, 1);
        chk("pre-reset count", count, 3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async rst mem_req", mem_req, 0);
        chk("async rst mem_addr", mem_addr, 0);
        chk("async rst count", count, 0);
        chk("async rst empty", empty, 1);
        chk("async rst overflow", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        push_entry({3'b110, 2'b01, 3'b101});
        step();
        idle_inputs();
        @(negedge clk);
        chk("post-reset count", count, 1);
        chk("post-reset mem_req idle", mem_req, 0);
        step();
        mem_ack = 1'b1;
        @(negedge clk);
        chk("post-reset mem_req", mem_req, 1);
        chk("post-reset mem_addr", mem_addr, 5'b11001);
        chk("post-reset mem_data", mem_data, 3'b101);
        step();
        mem_ack = 1'b0;
        @(negedge clk);
        chk("post-reset drained", count, 0);
        chk("post-reset empty", empty, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 Parameter DEPTH, default 4, number of buffer entries; SHALL be a power of two, 2..8.
REQ-002 clk  input  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 wb_valid  input  1  eviction strobe from the 2-way cache (its writeBack output); one entry per high cycle.
REQ-005 wb_tag  input  3  tag of the evicted line (cache tag_before).
REQ-006 wb_index  input  2  set index of the evicted line.
REQ-007 wb_data  input  3  data of the evicted line.
REQ-008 mem_req  output  1  write request to main memory.
REQ-009 mem_addr  output  5  {tag,index} of the head entry.
REQ-010 mem_data  output  3  data of the head entry.
REQ-011 mem_ack  input  1  memory accepted the write; meaningful only while mem_req=1.
REQ-012 snoop_tag  input  3  tag of a cache miss being refilled.
REQ-013 snoop_index  input  2  index of a cache miss being refilled.
REQ-014 snoop_hit  output  1  combinational: snoop address matches a pending entry.
REQ-015 snoop_data  output  3  combinational: data of the newest matching entry; 3'b000 when snoop_hit=0.
REQ-016 full  output  1  count==DEPTH.
REQ-017 empty  output  1  count==0.
REQ-018 count  output  4  number of pending entries, 0..DEPTH.
REQ-019 overflow  output  1  sticky: an eviction was dropped.

Function
REQ-020 Storage SHALL be a circular FIFO of DEPTH entries {tag[2:0], index[1:0], data[2:0]} with head/tail pointers wrapping modulo DEPTH.
REQ-021 Push: wb_valid=1 and full=0 at a rising edge SHALL write the entry at tail, advance tail, increment count.
REQ-022 wb_valid=1 while full=1 SHALL drop the entry, leave FIFO unchanged, set overflow=1 until reset; a pop in the same cycle SHALL NOT admit the push.
REQ-023 Drain FSM states: IDLE, REQ.
REQ-024 IDLE: mem_req=0; if empty=0 at a rising edge, go to REQ.
REQ-025 REQ: mem_req=1, mem_addr={head.tag,head.index}, mem_data=head.data, held stable until mem_ack.
REQ-026 REQ with mem_ack=1 at a rising edge SHALL pop the head (advance head, decrement count) and go to IDLE; mem_req SHALL be 0 the next cycle.
REQ-027 Minimum spacing: one IDLE cycle between consecutive requests; an entry pushed into an empty buffer at edge N SHALL see mem_req=1 after edge N+1.
REQ-028 Simultaneous push and pop with full=0: both SHALL occur; count unchanged.
REQ-029 mem_ack while in IDLE SHALL be ignored.
REQ-030 Snoop SHALL compare {snoop_tag,snoop_index} against all pending entries only (not free slots); with multiple matches, the most recently pushed SHALL supply snoop_data.
REQ-031 An entry being popped this cycle SHALL still be visible to snoop until the edge that pops it.
REQ-032 In IDLE, mem_addr and mem_data SHALL be 0.

Reset
REQ-033 rst_n=0 SHALL immediately force: FSM=IDLE, head=tail=0, count=0, empty=1, full=0, overflow=0, mem_req=0, mem_addr=0, mem_data=0.
REQ-034 Reset mid-request SHALL drop mem_req at once and discard all pending entries; entry storage contents need not be cleared.
REQ-035 Deassertion of rst_n SHALL take effect at the first rising edge after it; no push or FSM transition on that edge is lost.

Verification
REQ-036 Single eviction: push {tag=3'b101,index=2'b10,data=3'b011}, mem_ack after 3 cycles of mem_req -> mem_addr=5'b10110, mem_data=3'b011 stable throughout, count 1->0, empty=1.
REQ-037 Fill/overflow: 5 consecutive pushes with mem_ack=0 -> count=4, full=1 after 4th, 5th dropped, overflow=1 sticky; drain order equals push order.
REQ-038 Snoop: push {3'b001,2'b00,3'b100} then {3'b001,2'b00,3'b110}; snoop {3'b001,2'b00} -> snoop_hit=1, snoop_data=3'b110; snoop {3'b010,2'b00} -> snoop_hit=0, snoop_data=0.
REQ-039 Simultaneous push/pop at count=2 -> count stays 2, pointers wrap correctly across DEPTH boundary over 10 such cycles.
REQ-040 Reset during REQ with count=3 -> mem_req=0 asynchronously, count=0, empty=1, overflow=0; next push drains normally.
REQ-041 Spurious mem_ack=1 while empty -> no state change, count stays 0.
